// File: rtl/register_arbiter.sv
// ---------------------------------------------------------------------------
// register_arbiter
//
// Shares one loadable n-bit register among four requesters. A round-robin
// arbiter picks an owner. The owner may hold the grant across cycles with
// lock. While other requesters are waiting, that hold is bounded to
// MAX_HOLD consecutive cycles.
//
// The register's load/select are driven from the registered grant state.
// A request sampled on one edge produces grant/load/select in the next cycle.
// On the edge that ends that cycle, the register captures in[select].
// The new value appears on out, with valid=1, one cycle after that.
//
// Ports:
//   clock   - clock
//   reset   - asynchronous, active-high reset
//   req     - per-requester request, held high until granted
//   lock    - owner asks to keep the grant next cycle (ignored for others)
//   in0..3  - data from requesters 0..3
//   grant   - one-hot current owner, 0 when idle
//   load    - register loads this cycle (== |grant)
//   select  - owner index; holds its last value while idle
//   out     - shared register value
//   valid   - out was written on the previous edge
// ---------------------------------------------------------------------------
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module register_arbiter #(
    parameter int n        = `DEFAULT_WIDTH,
    parameter int MAX_HOLD = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   lock,
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic [n-1:0] in2,
    input  logic [n-1:0] in3,
    output logic [3:0]   grant,
    output logic         load,
    output logic [1:0]   select,
    output logic [n-1:0] out,
    output logic         valid
);
    // Wide enough to count up to MAX_HOLD inclusive.
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_reg;
    logic [3:0]      grant_reg;
    logic [1:0]      select_reg;
    logic [1:0]      ptr_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [n-1:0]    out_reg;
    logic            valid_reg;

    logic [n-1:0]    in_arr [4];
    logic [1:0]      win_idx;
    logic            win_found;
    logic [3:0]      others;
    logic            keep;

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    // Round-robin scan starting just after the last winner. With k=4 the
    // index wraps back to ptr itself. The previous owner therefore wins again
    // only if nobody else is requesting.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && req[ptr_reg + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_reg + 2'(k);
            end
        end
    end

    // Requests from everyone but the current owner (grant_reg is zero in
    // IDLE, so this is only meaningful in OWNED).
    assign others = req & ~grant_reg;

    // The owner keeps the grant while it still requests and locks. The hold
    // budget is not exhausted, unless nobody else is waiting: a lone locked
    // owner holds indefinitely.
    assign keep = req[select_reg] & lock[select_reg] &
                  ((hold_cnt_reg < HW'(MAX_HOLD)) | (others == 4'd0));

    // Arbitration FSM; grant/select are registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= 4'd0;
            select_reg   <= 2'd0;
            ptr_reg      <= 2'd3;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg    <= OWNED;
                        grant_reg    <= 4'd1 << win_idx;
                        select_reg   <= win_idx;
                        ptr_reg      <= win_idx;
                        hold_cnt_reg <= HW'(1);
                    end
                end
                OWNED: begin
                    if (keep) begin
                        if (hold_cnt_reg < HW'(MAX_HOLD))
                            hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end else if (win_found) begin
                        grant_reg    <= 4'd1 << win_idx;
                        select_reg   <= win_idx;
                        ptr_reg      <= win_idx;
                        hold_cnt_reg <= HW'(1);
                    end else begin
                        state_reg    <= IDLE;
                        grant_reg    <= 4'd0;
                        hold_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= 4'd0;
                end
            endcase
        end
    end

    // Shared register: captures the owner's data on every edge that ends a
    // granted cycle; valid echoes the previous cycle's load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= load;
            if (load)
                out_reg <= in_arr[select_reg];
        end
    end

    assign grant  = grant_reg;
    assign load   = |grant_reg;
    assign select = select_reg;
    assign out    = out_reg;
    assign valid  = valid_reg;

endmodule
